// File: rtl/roll_sequencer.sv
// Decelerating dice-roll sequencer driving the 4-bit random generator and hex displays.
// Optional ROLL_ABORT_EN: a start pulse during a roll cuts it short to the next capture.
module roll_sequencer #(
  parameter int VAL_W         = 4,
  parameter int CNT_W         = 26,
  parameter int BASE_INTERVAL = 2500000,
  parameter int MAX_INTERVAL  = 25000000,
  parameter int NUM_STEPS     = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [VAL_W-1:0] i_rand_value,
  output logic             o_advance,
  output logic [VAL_W-1:0] o_value,
  output logic [VAL_W-1:0] o_prev_value,
  output logic             o_busy,
  output logic             o_done
);

  localparam int SW = $clog2(NUM_STEPS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ADV,
    CAP,
    FIN
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] interval, interval_n;
  logic [CNT_W-1:0] next_iv;
  logic [SW-1:0]    step, step_n;
  logic [VAL_W-1:0] value_n, prev_n;
  logic             force_adv;
  logic             stop;

`ifdef ROLL_ABORT_EN
  logic abort, abort_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) abort <= 1'b0;
    else       abort <= abort_n;
  end

  always_comb begin
    abort_n = abort;
    if (state == IDLE) abort_n = 1'b0;
    else if (i_start && (state == WAIT || state == ADV || state == CAP))
      abort_n = 1'b1;
  end

  assign force_adv = i_start;
  assign stop      = abort | i_start;
`else
  assign force_adv = 1'b0;
  assign stop      = 1'b0;
`endif

  // Compare before shifting so the doubled interval can never overflow CNT_W.
  assign next_iv = (interval > CNT_W'(MAX_INTERVAL >> 1))
                 ? CNT_W'(MAX_INTERVAL)
                 : interval << 1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      interval     <= '0;
      step         <= '0;
      o_value      <= '0;
      o_prev_value <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      interval     <= interval_n;
      step         <= step_n;
      o_value      <= value_n;
      o_prev_value <= prev_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    interval_n = interval;
    step_n     = step;
    value_n    = o_value;
    prev_n     = o_prev_value;
    o_advance  = 1'b0;
    o_done     = 1'b0;
    o_busy     = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_n    = WAIT;
          cnt_n      = CNT_W'(BASE_INTERVAL - 1);
          interval_n = CNT_W'(BASE_INTERVAL);
          step_n     = '0;
          prev_n     = o_value;
        end
      end
      WAIT: begin
        if (cnt == '0 || force_adv) state_n = ADV;
        else                        cnt_n   = cnt - 1'b1;
      end
      ADV: begin
        o_advance = 1'b1;
        state_n   = CAP;
      end
      CAP: begin
        value_n = i_rand_value;
        step_n  = step + 1'b1;
        if (step == SW'(NUM_STEPS - 1) || stop) begin
          state_n = FIN;
        end else begin
          interval_n = next_iv;
          cnt_n      = next_iv - 1'b1;
          state_n    = WAIT;
        end
      end
      FIN: begin
        o_done  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_roll_sequencer.sv
// Randomized bench for roll_sequencer: two parameter sets checked against
// a schedule-based reference model (advance times computed per roll).
module tb_roll_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] rnd;
  logic [1:0] adv, busy, done;
  logic [3:0] val [2];
  logic [3:0] prev [2];

  always #5 clk = ~clk;

  roll_sequencer #(
    .VAL_W(4), .CNT_W(26), .BASE_INTERVAL(2),
    .MAX_INTERVAL(8), .NUM_STEPS(3)
  ) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_rand_value(rnd), .o_advance(adv[0]),
    .o_value(val[0]), .o_prev_value(prev[0]),
    .o_busy(busy[0]), .o_done(done[0])
  );

  roll_sequencer #(
    .VAL_W(4), .CNT_W(26), .BASE_INTERVAL(2),
    .MAX_INTERVAL(6), .NUM_STEPS(4)
  ) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_rand_value(rnd), .o_advance(adv[1]),
    .o_value(val[1]), .o_prev_value(prev[1]),
    .o_busy(busy[1]), .o_done(done[1])
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int  mb [2] = '{2, 2};
  int  mm [2] = '{8, 6};
  int  mn [2] = '{3, 4};
  int  adv_t [2][16];
  int  adv_n [2];
  int  done_t [2];
  bit  active [2];
  int  mval [2];
  int  mprev [2];

  function automatic bit is_adv(int i, int n);
    for (int k = 0; k < adv_n[i]; k++)
      if (adv_t[i][k] == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_cap(int i, int n);
    for (int k = 0; k < adv_n[i]; k++)
      if (adv_t[i][k] + 1 == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_check(int i, int n);
    bit ea, ed;
    if (rst) begin
      check($sformatf("u%0d rst busy@%0d", i, n), 32'(busy[i]), 0);
      check($sformatf("u%0d rst adv@%0d", i, n), 32'(adv[i]), 0);
      check($sformatf("u%0d rst done@%0d", i, n), 32'(done[i]), 0);
      check($sformatf("u%0d rst val@%0d", i, n), 32'(val[i]), 0);
      check($sformatf("u%0d rst prev@%0d", i, n), 32'(prev[i]), 0);
    end else begin
      ea = active[i] && is_adv(i, n);
      ed = active[i] && (n == done_t[i]);
      check($sformatf("u%0d busy@%0d", i, n), 32'(busy[i]), 32'(active[i]));
      check($sformatf("u%0d adv@%0d", i, n), 32'(adv[i]), 32'(ea));
      check($sformatf("u%0d done@%0d", i, n), 32'(done[i]), 32'(ed));
      check($sformatf("u%0d val@%0d", i, n), 32'(val[i]), 32'(mval[i]));
      check($sformatf("u%0d prev@%0d", i, n), 32'(prev[i]), 32'(mprev[i]));
    end
  endtask

  task automatic model_step(int i, int n);
    int t, iv;
    if (rst) begin
      active[i] = 0;
      mval[i]   = 0;
      mprev[i]  = 0;
      adv_n[i]  = 0;
      done_t[i] = -1;
      return;
    end
    if (active[i]) begin
`ifdef ROLL_ABORT_EN
      if (start && n < done_t[i]) begin
        if (is_adv(i, n)) begin
          done_t[i] = n + 2;
        end else if (is_cap(i, n)) begin
          done_t[i] = n + 1;
        end else begin
          for (int k = 0; k < adv_n[i]; k++)
            if (adv_t[i][k] > n) begin
              adv_t[i][k] = n + 1;
              adv_n[i]    = k + 1;
              break;
            end
          done_t[i] = n + 3;
        end
        for (int k = 0; k < adv_n[i]; k++)
          if (adv_t[i][k] >= done_t[i]) begin
            adv_n[i] = k;
            break;
          end
      end
`endif
      if (is_cap(i, n)) mval[i] = int'(rnd);
      if (n == done_t[i]) active[i] = 0;
    end else if (start) begin
      active[i] = 1;
      mprev[i]  = mval[i];
      iv = mb[i];
      t  = n + iv + 1;
      for (int k = 0; k < mn[i]; k++) begin
        adv_t[i][k] = t;
        iv = (iv > mm[i] / 2) ? mm[i] : iv * 2;
        t  = t + iv + 2;
      end
      adv_n[i]  = mn[i];
      done_t[i] = adv_t[i][mn[i] - 1] + 2;
    end
  endtask

  int first_adv [$];
  int first_done = -1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      active[i] = 0; mval[i] = 0; mprev[i] = 0;
      adv_n[i] = 0; done_t[i] = -1;
    end
    rst = 1'b1; start = 1'b0; rnd = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 4000; n++) begin
      rst   = (n >= 30) && ($urandom % 400 == 0);
      if (n == 0)      start = 1'b1;
      else if (n < 30) start = 1'b0;
      else             start = ($urandom % 30 == 0);
      rnd = 4'($urandom);
      @(negedge clk);
      for (int i = 0; i < 2; i++) model_check(i, n);
      if (n < 30 && adv[0]) first_adv.push_back(n);
      if (n < 30 && done[0] && first_done < 0) first_done = n;
      for (int i = 0; i < 2; i++) model_step(i, n);
      @(posedge clk);
      #1;
    end
    check("first roll adv count", 32'(first_adv.size()), 3);
    if (first_adv.size() == 3) begin
      check("first adv0", 32'(first_adv[0]), 3);
      check("first adv1", 32'(first_adv[1]), 9);
      check("first adv2", 32'(first_adv[2]), 19);
    end
    check("first done", 32'(first_done), 21);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
